uart_rx: RTL

8N1 UART receiver forming the receive path of the UART `top`, the complement of the existing transmitter (`parallel_in`/`t_enable`/`busy`/`serial_out`). It converts asynchronous serial data on `serial_in` into bytes on `parallel_out`, flagging each good byte with a one-cycle `rx_valid` pulse and each bad stop bit with `frame_error`. It runs on the 100 MHz system clock at 115200 baud by default, and supports loopback from the transmitter's `serial_out`.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling driven by a
// 10-bit bit-timing counter, and a small FSM that emits a one-cycle rx_valid
// for each good frame or a one-cycle frame_error for a bad stop bit.
//
// Handshake: rx_valid is a single-cycle strobe with no ready/back-pressure;
// parallel_out changes only on the edge that raises rx_valid and is held
// until the next good frame. frame_error is an independent single-cycle
// strobe and is never asserted in the same cycle as rx_valid.
module uart_rx #(
  parameter int CLK_HZ         = 100000000,
  parameter int BIT_RATE       = 115200,
  parameter int CYCLES_PER_BIT = CLK_HZ / BIT_RATE,
  parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] parallel_out,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [9:0] LAST_BIT  = 10'(CYCLES_PER_BIT - 1);
  localparam logic [9:0] LAST_HALF = 10'(HALF_BIT - 1);

  state_t     state, state_n;
  logic [1:0] sync_q;
  logic       rx_sync;
  logic [9:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic       load_n, valid_n, ferr_n;

  assign rx_sync = sync_q[1];
  assign busy    = (state != IDLE);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], serial_in};
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      parallel_out <= 8'h00;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      rx_valid    <= valid_n;
      frame_error <= ferr_n;
      if (load_n) parallel_out <= shift;
    end
  end

  // Next-state logic: sample at half-bit for the start bit, then at full-bit
  // intervals, which lands every later sample in the middle of its bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 10'd1;
    idx_n   = idx;
    shift_n = shift;
    load_n  = 1'b0;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = START;
      end
      START: begin
        if (cnt == LAST_HALF) begin
          cnt_n = '0;
          if (!rx_sync) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST_BIT) begin
          cnt_n = '0;
          if (rx_sync) begin
            load_n  = 1'b1;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off re-arming until the line returns high so a break reports once.
        cnt_n = '0;
        if (rx_sync) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
